// File: rtl/hilo_muldiv_if.sv
// HI/LO multiply/divide request and result bundle between the execute stage and the engine.
// Latency: wiring only.
// Backpressure: busy from the slave tells the master that requests are being dropped.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op, src_a, src_b,
        input  busy, div_zero, hi, lo
    );

    modport slave (
        input  op_valid, op, src_a, src_b,
        output busy, div_zero, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with single-cycle MT/multiply/MAC ops and a restoring iterative divider.
// Latency: single-cycle ops land at the accepting edge; divides write HI/LO WIDTH+1 edges later.
// Backpressure: busy is high during a divide and requests presented then are dropped, not queued.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    hilo_muldiv_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_MTHI  = 4'd1;
    localparam logic [3:0] OP_MTLO  = 4'd2;
    localparam logic [3:0] OP_MULT  = 4'd3;
    localparam logic [3:0] OP_MULTU = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_DIV   = 4'd9;
    localparam logic [3:0] OP_DIVU  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIX
    } state_t;

    state_t state;
    state_t stateNext;

    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic             divZeroReg;

    // Divider working state: quo starts as |dividend| and shifts quotient bits in from the right.
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] dividendRaw;
    logic             negQuo;
    logic             negRem;
    logic             zeroDiv;
    logic [CW-1:0]    cnt;

    logic accept;
    logic startDiv;
    logic iterate;
    logic finish;

    logic             mulSigned;
    logic [W2-1:0]    mulA;
    logic [W2-1:0]    mulB;
    logic [W2-1:0]    product;
    logic [W2-1:0]    hiLo;

    logic             divSigned;
    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign accept = bus.op_valid && (state == S_IDLE) && !rst;

    // Multiplier operands are extended to 2*WIDTH so the truncated product is exact mod 2^(2*WIDTH).
    always_comb begin
        mulSigned = (bus.op == OP_MULT) || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
        mulA      = mulSigned ? {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a} : {{WIDTH{1'b0}}, bus.src_a};
        mulB      = mulSigned ? {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b} : {{WIDTH{1'b0}}, bus.src_b};
        product   = mulA * mulB;
        hiLo      = {hiReg, loReg};
    end

    // Operand magnitudes and signs captured when a divide is accepted.
    always_comb begin
        divSigned = (bus.op == OP_DIV);
        aNeg      = divSigned && bus.src_a[WIDTH-1];
        bNeg      = divSigned && bus.src_b[WIDTH-1];
        absA      = aNeg ? (~bus.src_a + 1'b1) : bus.src_a;
        absB      = bNeg ? (~bus.src_b + 1'b1) : bus.src_b;
    end

    // One restoring step: shift in the next dividend bit and subtract if the divisor fits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
    end

    // Sequencer state register; reset abandons any in-flight divide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and per-cycle datapath strobes.
    always_comb begin
        stateNext = state;
        startDiv  = 1'b0;
        iterate   = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && ((bus.op == OP_DIV) || (bus.op == OP_DIVU))) begin
                    startDiv  = 1'b1;
                    stateNext = S_DIV;
                end
            end
            S_DIV: begin
                iterate = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    stateNext = S_FIX;
                end
            end
            S_FIX: begin
                finish    = 1'b1;
                stateNext = S_IDLE;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    // HI/LO registers, divider working registers and the div_zero pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hiReg       <= '0;
            loReg       <= '0;
            divZeroReg  <= 1'b0;
            quo         <= '0;
            rem         <= '0;
            divisor     <= '0;
            dividendRaw <= '0;
            negQuo      <= 1'b0;
            negRem      <= 1'b0;
            zeroDiv     <= 1'b0;
            cnt         <= '0;
        end else begin
            divZeroReg <= 1'b0;

            if (accept) begin
                case (bus.op)
                    OP_MTHI:            hiReg <= bus.src_a;
                    OP_MTLO:            loReg <= bus.src_a;
                    OP_MULT, OP_MULTU:  {hiReg, loReg} <= product;
                    OP_MADD, OP_MADDU:  {hiReg, loReg} <= hiLo + product;
                    OP_MSUB, OP_MSUBU:  {hiReg, loReg} <= hiLo - product;
                    default: ;
                endcase
            end

            if (startDiv) begin
                quo         <= absA;
                rem         <= '0;
                divisor     <= absB;
                dividendRaw <= bus.src_a;
                negQuo      <= aNeg ^ bNeg;
                negRem      <= aNeg;
                zeroDiv     <= (bus.src_b == '0);
                cnt         <= '0;
            end

            if (iterate) begin
                cnt <= cnt + 1'b1;
                if (!trial[WIDTH]) begin
                    rem <= trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end

            // Most-negative / -1 needs no special case: the negated magnitude wraps back to most-negative.
            if (finish) begin
                cnt        <= '0;
                divZeroReg <= zeroDiv;
                if (zeroDiv) begin
                    loReg <= '1;
                    hiReg <= dividendRaw;
                end else begin
                    loReg <= negQuo ? (~quo + 1'b1) : quo;
                    hiReg <= negRem ? (~rem + 1'b1) : rem;
                end
            end
        end
    end

    assign bus.busy     = (state != S_IDLE);
    assign bus.div_zero = divZeroReg;
    assign bus.hi       = (accept && (bus.op == OP_MTHI)) ? bus.src_a : hiReg;
    assign bus.lo       = (accept && (bus.op == OP_MTLO)) ? bus.src_a : loReg;
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised HI/LO register pair with an integrated multiply, multiply-accumulate and iterative divide engine, sitting beside the register file in the execute stage. Single-cycle ops (MTHI/MTLO/multiply family) write HI/LO at the accepting edge. Divides run a WIDTH-step restoring algorithm and hold `busy` so the pipeline stalls. MTHI/MTLO values are forwarded to the outputs in the same cycle.

## Interface
- WIDTH, 32, operand and HI/LO register width; must be ≥ 4 and even.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- op_valid  in  1  op request this cycle.
- op  in  4  operation code, see Operation.
- src_a  in  WIDTH  operand A: dividend, multiplicand, or MTHI/MTLO data.
- src_b  in  WIDTH  operand B: divisor or multiplier.
- busy  out  1  divide in progress; requests are ignored while high.
- div_zero  out  1  one-cycle pulse at completion of a divide whose divisor was 0.
- hi  out  WIDTH  HI value, forwarded for accepted MTHI.
- lo  out  WIDTH  LO value, forwarded for accepted MTLO.

## Operation
- Codes: 0 NOP, 1 MTHI, 2 MTLO, 3 MULT, 4 MULTU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 DIV, 10 DIVU. Codes 11–15 are treated as NOP.
- Accept condition: `op_valid && !busy && !rst`. Nothing else changes state.
- MTHI/MTLO: write src_a to HI or LO. The other register is unchanged.
- MULT/MULTU: {HI,LO} ← src_a × src_b as a 2·WIDTH-bit signed or unsigned product.
- MADD(U): {HI,LO} ← {HI,LO} + product. MSUB(U): {HI,LO} ← {HI,LO} − product. Both wrap modulo 2^(2·WIDTH).
- DIV/DIVU:
  - Latch operands. For signed divides, latch absolute values and the sign bits.
  - Run WIDTH restoring iterations, then one fix-up step.
  - Results: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - Signed overflow (most-negative ÷ −1): LO = most-negative, HI = 0.
- Divide by zero: LO = all ones, HI = src_a. Latency is the same as a normal divide, and div_zero pulses.
- State machine:
  - IDLE → DIV on an accepted DIV/DIVU.
  - DIV runs WIDTH iterations with counter 0..WIDTH−1, then → FIX.
  - FIX applies signs, writes HI/LO, pulses div_zero if needed, then → IDLE.
- `busy` = (state != IDLE), decoded from registered state.
- Forwarding: while an MTHI is accepted, `hi` = src_a combinationally; same for MTLO and `lo`. Otherwise both outputs show the registered values.
- Multiply-family results are visible only after the accepting edge.

## Timing
- Reset values: HI=0, LO=0, state=IDLE, busy=0, div_zero=0.
- rst has priority over everything, including an in-flight divide. The divide is abandoned and HI/LO read 0 after the edge.
- Single-cycle ops: accepted at edge E0, registered result visible from E0 onward.
- Divide:
  - Accepted at E0; busy is high from after E0 until FIX completes at E_{WIDTH+1}.
  - HI/LO update at E_{WIDTH+1}, and busy reads 0 in the following cycle.
  - Total busy cycles = WIDTH+1 (33 for WIDTH=32). div_zero is high in the cycle after E_{WIDTH+1} only.
- While busy:
  - HI/LO hold their pre-divide values.
  - op_valid is ignored; the caller must re-present the request.
  - MTHI/MTLO are not forwarded.
- Back-to-back: a new op may be accepted in the first cycle busy reads 0.
- MADD reading HI/LO immediately after an MTHI/MULT uses the updated registered value; no hazard exists inside the block.

## Test plan
- Reset, then idle: hi=lo=0, busy=0. Hold op_valid=1 with op=11 → no change.
- MTHI src_a=0x12345678 → `hi`=0x12345678 in the same cycle, held after the edge, lo still 0. Then MTLO 0xCAFEBABE → lo updates, hi unchanged.
- MULT src_a=−3, src_b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE. MADDU 1×1 → lo=0xFFFFFFFF, hi=1. MSUB 1×1 → lo=0xFFFFFFFE, hi=1.
- DIV −7/2 → busy high exactly 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- DIVU 5/0 → after 33 cycles lo=0xFFFFFFFF, hi=5, div_zero high for exactly one cycle. An MTHI presented mid-divide is ignored and not forwarded.
- Start DIV, assert rst at iteration 10 → next cycle busy=0, hi=lo=0. A MULT 2×3 issued right after reset → lo=6, hi=0.
